// File: rtl/path_sequencer_pkg.sv
// Shared constants for the path planner / path sequencer pair: graph geometry, path word layout, FSM encodings.
// Latency: n/a (constants and a combinational slot-select helper).
// Backpressure: n/a.
package path_sequencer_pkg;

    localparam int NODE_COUNT = 27;   // legal node ids 0..NODE_COUNT-2
    localparam int MAX_SLOTS  = 10;   // node slots in the packed path word
    localparam int NODE_W     = 5;    // bits per node id
    localparam int TERM_NODE  = 27;   // predecessor-of-start marker
    localparam int PATH_W     = MAX_SLOTS * NODE_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_TRAVEL = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef logic [NODE_W-1:0] node_t;

    // Mux-based slot select; indices >= MAX_SLOTS return 0 instead of
    // reading past the end of the path word.
    function automatic node_t slot_of(input logic [PATH_W-1:0] path, input logic [3:0] k);
        node_t r;
        r = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (k == 4'(i)) begin
                r = path[i*NODE_W +: NODE_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/path_len_finder.sv
// Purpose: finds the path length (index of the lowest terminator slot, else MAX_SLOTS) and flags out-of-range ids.
// Latency: combinational. Backpressure: none.
// Ports: path (packed path word) -> len (0..MAX_SLOTS), range_err (a slot below len holds an id >= NODE_COUNT-1).
module path_len_finder
    import path_sequencer_pkg::*;
(
    input  logic [PATH_W-1:0] path,
    output logic [3:0]        len,
    output logic              range_err
);

    logic found;

    always_comb begin
        len       = 4'(MAX_SLOTS);
        found     = 1'b0;
        range_err = 1'b0;
        // Priority encode: lowest terminator wins.
        for (int k = 0; k < MAX_SLOTS; k++) begin
            if (!found && (path[k*NODE_W +: NODE_W] == NODE_W'(TERM_NODE))) begin
                len   = 4'(k);
                found = 1'b1;
            end
        end
        // Only slots that are part of the path are range checked; the
        // terminator itself sits at index len and is excluded.
        for (int k = 0; k < MAX_SLOTS; k++) begin
            if ((4'(k) < len) && (path[k*NODE_W +: NODE_W] >= NODE_W'(NODE_COUNT - 1))) begin
                range_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_sequencer.sv
// Purpose: latches the planner's path on path_valid rise, then issues waypoints start->end, one per arrival report.
// Latency: path edge at cycle T -> first cmd_valid at T+2; start==end -> path_done at T+2.
// Backpressure: cmd_valid/cmd_node hold stable until cmd_ready; next waypoint only after node_reached confirms the last.
// Ports: clk, rst_n (async active-low); path_valid/path_in from planner; abort; cmd_valid/cmd_ready/cmd_node to motion;
//        node_reached/reached_node from junction detect; cur_node, hops_left, busy, path_done, path_err status.
module path_sequencer
    import path_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              path_valid,
    input  logic [PATH_W-1:0] path_in,
    input  logic              abort,
    input  logic              cmd_ready,
    input  logic              node_reached,
    input  logic [NODE_W-1:0] reached_node,
    output logic              cmd_valid,
    output logic [NODE_W-1:0] cmd_node,
    output logic [NODE_W-1:0] cur_node,
    output logic [3:0]        hops_left,
    output logic              busy,
    output logic              path_done,
    output logic              path_err
);

    logic [2:0]        state;
    logic              pv_q;
    logic              pv_edge;
    logic [PATH_W-1:0] path_q;
    logic [3:0]        idx;
    logic [3:0]        len;
    logic              range_err;

    node_t slot_idx;    // waypoint currently commanded / travelled to
    node_t slot_next;   // waypoint after the current one (idx-1)
    node_t slot_start;  // start node, slot[len-1]
    node_t slot_first;  // first waypoint, slot[len-2]

    path_len_finder u_len (
        .path      (path_q),
        .len       (len),
        .range_err (range_err)
    );

    assign pv_edge    = path_valid & ~pv_q;
    assign slot_idx   = slot_of(path_q, idx);
    assign slot_next  = slot_of(path_q, 4'(idx - 4'd1));
    assign slot_start = slot_of(path_q, 4'(len - 4'd1));
    assign slot_first = slot_of(path_q, 4'(len - 4'd2));

    assign busy      = (state == ST_SCAN) || (state == ST_ISSUE) || (state == ST_TRAVEL);
    assign path_done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pv_q      <= 1'b0;
            path_q    <= '0;
            idx       <= '0;
            cmd_valid <= 1'b0;
            cmd_node  <= '0;
            cur_node  <= '0;
            hops_left <= '0;
            path_err  <= 1'b0;
        end else begin
            // Edge tracker runs in every state so a level held high across
            // a busy period never looks like a new path later.
            pv_q <= path_valid;

            if ((state != ST_IDLE) && abort) begin
                state     <= ST_IDLE;
                cmd_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pv_edge) begin
                            path_q   <= path_in;
                            path_err <= 1'b0;
                            state    <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if ((len == 4'd0) || range_err) begin
                            path_err <= 1'b1;
                            state    <= ST_IDLE;
                        end else if (len == 4'd1) begin
                            cur_node  <= slot_of(path_q, 4'd0);
                            hops_left <= 4'd0;
                            state     <= ST_DONE;
                        end else begin
                            cur_node  <= slot_start;
                            idx       <= 4'(len - 4'd2);
                            hops_left <= 4'(len - 4'd1);
                            cmd_valid <= 1'b1;
                            cmd_node  <= slot_first;
                            state     <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        // node_reached is deliberately ignored until the
                        // command has been accepted.
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            state     <= ST_TRAVEL;
                        end
                    end
                    ST_TRAVEL: begin
                        if (node_reached) begin
                            if (reached_node != slot_idx) begin
                                path_err <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                cur_node <= reached_node;
                                if (hops_left != 4'd0) begin
                                    hops_left <= hops_left - 4'd1;
                                end
                                if (idx == 4'd0) begin
                                    state <= ST_DONE;
                                end else begin
                                    idx       <= idx - 4'd1;
                                    cmd_valid <= 1'b1;
                                    cmd_node  <= slot_next;
                                    state     <= ST_ISSUE;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_path_sequencer.sv
module tb_path_sequencer;

    logic        clk;
    logic        rst_n;
    logic        path_valid;
    logic [49:0] path_in;
    logic        abort;
    logic        cmd_ready;
    logic        node_reached;
    logic [4:0]  reached_node;
    logic        cmd_valid;
    logic [4:0]  cmd_node;
    logic [4:0]  cur_node;
    logic [3:0]  hops_left;
    logic        busy;
    logic        path_done;
    logic        path_err;

    int errors = 0;
    int checks = 0;

    typedef logic [4:0] slots_t [10];

    path_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .path_valid   (path_valid),
        .path_in      (path_in),
        .abort        (abort),
        .cmd_ready    (cmd_ready),
        .node_reached (node_reached),
        .reached_node (reached_node),
        .cmd_valid    (cmd_valid),
        .cmd_node     (cmd_node),
        .cur_node     (cur_node),
        .hops_left    (hops_left),
        .busy         (busy),
        .path_done    (path_done),
        .path_err     (path_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [49:0] pk(input slots_t s);
        logic [49:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[i*5 +: 5] = s[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rising edge on path_valid; on return the DUT is in SCAN.
    task automatic launch(input logic [49:0] p);
        path_in    = p;
        path_valid = 1'b1;
        tick();
        path_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; path_valid = 1'b0; path_in = '0; abort = 1'b0;
        cmd_ready = 1'b0; node_reached = 1'b0; reached_node = '0;
        tick();
        checks++; if ({cmd_valid, cmd_node, cur_node, hops_left, busy, path_done, path_err} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {cmd_valid, cmd_node, cur_node, hops_left, busy, path_done, path_err}); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%0d exp=0", busy); end
    endtask

    // 0->1->2->3 with immediate acceptance and correct arrivals.
    task automatic test_walk();
        logic [4:0] exp_cmd [3];
        exp_cmd[0] = 5'd1; exp_cmd[1] = 5'd2; exp_cmd[2] = 5'd3;
        cmd_ready = 1'b1;
        launch(pk('{5'd3, 5'd2, 5'd1, 5'd0, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27}));
        checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL walk_scan busy=%0d cmd_valid=%0d exp busy=1 cmd_valid=0", busy, cmd_valid); end
        tick();
        checks++; if (cur_node !== 5'd0) begin errors++; $display("FAIL walk_start_node got=%0d exp=0", cur_node); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_node !== exp_cmd[i] || hops_left !== 4'(3 - i)) begin
                errors++; $display("FAIL walk_issue%0d valid=%0d node=%0d hops=%0d exp 1/%0d/%0d", i, cmd_valid, cmd_node, hops_left, exp_cmd[i], 3 - i); end
            tick();
            checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL walk_travel%0d valid=%0d busy=%0d exp 0/1", i, cmd_valid, busy); end
            node_reached = 1'b1; reached_node = exp_cmd[i];
            tick();
            node_reached = 1'b0;
            checks++; if (cur_node !== exp_cmd[i] || hops_left !== 4'(2 - i)) begin
                errors++; $display("FAIL walk_arrive%0d cur=%0d hops=%0d exp %0d/%0d", i, cur_node, hops_left, exp_cmd[i], 2 - i); end
        end
        checks++; if (path_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL walk_done path_done=%0d busy=%0d exp 1/0", path_done, busy); end
        tick();
        checks++; if (path_done !== 1'b0) begin errors++; $display("FAIL walk_done_single got=%0d exp=0", path_done); end
    endtask

    // Start equals end: no command, path_done two cycles after the edge.
    task automatic test_single_node();
        launch(pk('{5'd5, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        checks++; if (path_done !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_early done=%0d valid=%0d exp 0/0", path_done, cmd_valid); end
        tick();
        checks++; if (path_done !== 1'b1 || cur_node !== 5'd5 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_done done=%0d cur=%0d valid=%0d exp 1/5/0", path_done, cur_node, cmd_valid); end
        tick();
        checks++; if (path_done !== 1'b0) begin errors++; $display("FAIL single_pulse got=%0d exp=0", path_done); end
    endtask

    // Command held while cmd_ready is low; arrival pulses in ISSUE ignored.
    task automatic test_backpressure();
        cmd_ready = 1'b0;
        launch(pk('{5'd3, 5'd2, 5'd1, 5'd0, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27}));
        tick();
        for (int i = 0; i < 5; i++) begin
            node_reached = 1'b1; reached_node = 5'd1;
            tick();
            checks++; if (cmd_valid !== 1'b1 || cmd_node !== 5'd1 || cur_node !== 5'd0 || hops_left !== 4'd3) begin
                errors++; $display("FAIL hold%0d valid=%0d node=%0d cur=%0d hops=%0d exp 1/1/0/3", i, cmd_valid, cmd_node, cur_node, hops_left); end
        end
        node_reached = 1'b0;
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL hold_accept valid=%0d busy=%0d exp 0/1", cmd_valid, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Wrong arrival report -> sticky error, cleared by the next accepted path.
    task automatic test_wrong_node();
        cmd_ready = 1'b1;
        launch(pk('{5'd3, 5'd2, 5'd1, 5'd0, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27}));
        tick(); tick();
        node_reached = 1'b1; reached_node = 5'd1;
        tick();
        node_reached = 1'b0;
        tick();
        node_reached = 1'b1; reached_node = 5'd13;
        tick();
        node_reached = 1'b0;
        checks++; if (path_err !== 1'b1 || busy !== 1'b0 || path_done !== 1'b0) begin
            errors++; $display("FAIL wrong_node err=%0d busy=%0d done=%0d exp 1/0/0", path_err, busy, path_done); end
        tick();
        launch(pk('{5'd5, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        checks++; if (path_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%0d exp=0", path_err); end
        tick(); tick();
    endtask

    // Abort in TRAVEL; path_valid re-raised while busy is ignored.
    task automatic test_abort();
        cmd_ready = 1'b1;
        launch(pk('{5'd3, 5'd2, 5'd1, 5'd0, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27}));
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || path_done !== 1'b0) begin
            errors++; $display("FAIL abort_travel busy=%0d valid=%0d done=%0d exp 0/0/0", busy, cmd_valid, path_done); end
        tick();
        checks++; if (path_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_nopulse done=%0d busy=%0d exp 0/0", path_done, busy); end

        cmd_ready = 1'b0;
        launch(pk('{5'd3, 5'd2, 5'd1, 5'd0, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd27}));
        tick();
        path_in = pk('{5'd5, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0});
        path_valid = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_node !== 5'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_edge_ignored valid=%0d node=%0d busy=%0d exp 1/1/1", cmd_valid, cmd_node, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_level_no_start busy=%0d exp=0", busy); end
        path_valid = 1'b0;
        tick();
        launch(pk('{5'd5, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fresh_scan busy=%0d exp=1", busy); end
        tick();
        checks++; if (path_done !== 1'b1 || cur_node !== 5'd5) begin
            errors++; $display("FAIL fresh_done done=%0d cur=%0d exp 1/5", path_done, cur_node); end
        tick();
    endtask

    // Malformed paths, full-length path, async reset mid-ISSUE.
    task automatic test_boundaries();
        launch(pk('{5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        tick();
        checks++; if (path_err !== 1'b1 || busy !== 1'b0 || path_done !== 1'b0) begin
            errors++; $display("FAIL len0_err err=%0d busy=%0d done=%0d exp 1/0/0", path_err, busy, path_done); end
        launch(pk('{5'd4, 5'd26, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}));
        checks++; if (path_err !== 1'b0) begin errors++; $display("FAIL err_clear2 got=%0d exp=0", path_err); end
        tick();
        checks++; if (path_err !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL id26_err err=%0d valid=%0d busy=%0d exp 1/0/0", path_err, cmd_valid, busy); end

        cmd_ready = 1'b0;
        launch(pk('{5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_node !== 5'd1 || cur_node !== 5'd0 || hops_left !== 4'd9 || path_err !== 1'b0) begin
            errors++; $display("FAIL full_len valid=%0d node=%0d cur=%0d hops=%0d err=%0d exp 1/1/0/9/0", cmd_valid, cmd_node, cur_node, hops_left, path_err); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_valid, cmd_node, cur_node, hops_left, busy, path_done, path_err} !== 19'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", {cmd_valid, cmd_node, cur_node, hops_left, busy, path_done, path_err}); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset busy=%0d valid=%0d exp 0/0", busy, cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_single_node();
        test_backpressure();
        test_wrong_node();
        test_abort();
        test_boundaries();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
